// File: rtl/controller.sv
// Multicycle control FSM for the 16-bit CPU: fetches into an instruction register,
// sequences the datapath per state and owns the Z/N/C/F flag register.
module controller #(
  parameter int WIDTH = 16,
  parameter int IMM   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instr,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_c,
  input  logic             alu_f,
  output logic             wa_s,
  output logic             pc_s,
  output logic             alub_s,
  output logic             mem_s,
  output logic [1:0]       wd_s,
  output logic [1:0]       alua_s,
  output logic             pcen,
  output logic             regwrite,
  output logic             mem_we,
  output logic             signext_sign,
  output logic [3:0]       opcode,
  output logic [3:0]       opext,
  output logic [3:0]       rsrc_addr,
  output logic [3:0]       rdest_addr,
  output logic [IMM-1:0]   imm,
  output logic             illegal,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_LATCH = 3'd1,
    S_EXEC  = 3'd2,
    S_LDMEM = 3'd3,
    S_LDWB  = 3'd4
  } state_t;

  typedef struct packed {
    logic           wa_s;
    logic           pc_s;
    logic           alub_s;
    logic           mem_s;
    logic [1:0]     wd_s;
    logic [1:0]     alua_s;
    logic           pcen;
    logic           regwrite;
    logic           mem_we;
    logic           signext_sign;
    logic [3:0]     opcode;
    logic [3:0]     opext;
    logic [IMM-1:0] imm;
    logic           illegal;
  } ctrl_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [3:0]       flags_q, flags_d;  // {Z, N, C, F}
  ctrl_t            ctrl_q;

  function automatic logic cond_taken(input logic [3:0] cnd, input logic [3:0] fl);
    logic t;
    case (cnd)
      4'b0000: t = fl[3];
      4'b0001: t = !fl[3];
      4'b0010: t = fl[1];
      4'b0011: t = !fl[1];
      4'b0100: t = fl[0];
      4'b0101: t = !fl[0];
      4'b0110: t = fl[2];
      4'b0111: t = !fl[2];
      4'b1110: t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Only ADD/SUB/CMP and their immediate forms update the flags.
  function automatic logic sets_flags(input logic [WIDTH-1:0] ir);
    logic [3:0] op, ext;
    op  = ir[15:12];
    ext = ir[7:4];
    return ((op == 4'b0000) && (ext == 4'b0101 || ext == 4'b1001 || ext == 4'b1011)) ||
           (op == 4'b0101 || op == 4'b1001 || op == 4'b1011);
  endfunction

  function automatic ctrl_t decode(input state_t st, input logic [WIDTH-1:0] ir,
                                   input logic [3:0] fl);
    ctrl_t      c;
    logic [3:0] op, ext, cnd;
    op  = ir[15:12];
    cnd = ir[11:8];
    ext = ir[7:4];
    c          = '0;
    c.wa_s     = 1'b1;
    c.wd_s     = 2'b11;
    c.imm      = IMM'(ir[7:0]);
    case (st)
      S_FETCH: ;
      S_LATCH: begin
        c.alua_s = 2'b01;
        c.alub_s = 1'b1;
        c.imm    = IMM'(1);
        c.opext  = 4'b0101;
        c.pcen   = 1'b1;
      end
      S_EXEC: begin
        case (op)
          4'b0000: begin
            case (ext)
              4'b0101, 4'b1001, 4'b1011, 4'b0001, 4'b0010, 4'b0011, 4'b1101: begin
                c.opext    = ext;
                c.regwrite = (ext != 4'b1011);
              end
              default: c.illegal = 1'b1;
            endcase
          end
          4'b0101, 4'b1001, 4'b1011, 4'b0001, 4'b0010, 4'b0011: begin
            c.alub_s       = 1'b1;
            c.opcode       = op;
            c.signext_sign = (op == 4'b0101 || op == 4'b1001 || op == 4'b1011);
            c.regwrite     = (op != 4'b1011);
          end
          4'b1101: begin
            c.alua_s   = 2'b10;
            c.alub_s   = 1'b1;
            c.opext    = 4'b0101;
            c.regwrite = 1'b1;
          end
          4'b1100: begin
            if (cond_taken(cnd, fl)) begin
              c.alua_s       = 2'b01;
              c.alub_s       = 1'b1;
              c.signext_sign = 1'b1;
              c.opext        = 4'b0101;
              c.pcen         = 1'b1;
            end
          end
          4'b0100: begin
            case (ext)
              4'b0000: ;
              4'b0100: begin
                c.mem_s  = 1'b1;
                c.mem_we = 1'b1;
              end
              4'b1100: begin
                if (cond_taken(cnd, fl)) begin
                  c.pc_s = 1'b1;
                  c.pcen = 1'b1;
                end
              end
              4'b1000: begin
                c.regwrite = 1'b1;
                c.wd_s     = 2'b01;
                c.pc_s     = 1'b1;
                c.pcen     = 1'b1;
              end
              default: c.illegal = 1'b1;
            endcase
          end
          default: c.illegal = 1'b1;
        endcase
      end
      S_LDMEM: c.mem_s = 1'b1;
      S_LDWB: begin
        c.mem_s    = 1'b1;
        c.wd_s     = 2'b00;
        c.regwrite = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    case (state_q)
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        ir_d    = instr;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = (ir_q[15:12] == 4'b0100 && ir_q[7:4] == 4'b0000) ? S_LDMEM : S_FETCH;
        if (sets_flags(ir_q)) flags_d = {alu_z, alu_n, alu_c, alu_f};
      end
      S_LDMEM: state_d = S_LDWB;
      S_LDWB:  state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      flags_q <= '0;
      ctrl_q  <= decode(S_FETCH, '0, '0);
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      ctrl_q  <= decode(state_d, ir_d, flags_d);
    end
  end

  assign wa_s         = ctrl_q.wa_s;
  assign pc_s         = ctrl_q.pc_s;
  assign alub_s       = ctrl_q.alub_s;
  assign mem_s        = ctrl_q.mem_s;
  assign wd_s         = ctrl_q.wd_s;
  assign alua_s       = ctrl_q.alua_s;
  assign pcen         = ctrl_q.pcen;
  assign regwrite     = ctrl_q.regwrite;
  assign mem_we       = ctrl_q.mem_we;
  assign signext_sign = ctrl_q.signext_sign;
  assign opcode       = ctrl_q.opcode;
  assign opext        = ctrl_q.opext;
  assign imm          = ctrl_q.imm;
  assign illegal      = ctrl_q.illegal;
  assign rsrc_addr    = ir_q[3:0];
  assign rdest_addr   = ir_q[11:8];
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_controller.sv
// Directed bench for the multicycle controller: one task per scenario, each
// stepping instructions through FETCH/LATCH/EXEC and comparing the control outputs.
module tb_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        alu_z, alu_n, alu_c, alu_f;
  logic        wa_s, pc_s, alub_s, mem_s;
  logic [1:0]  wd_s, alua_s;
  logic        pcen, regwrite, mem_we, signext_sign;
  logic [3:0]  opcode, opext, rsrc_addr, rdest_addr;
  logic [7:0]  imm;
  logic        illegal;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  controller #(.WIDTH(16), .IMM(8)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_f(alu_f),
    .wa_s(wa_s), .pc_s(pc_s), .alub_s(alub_s), .mem_s(mem_s),
    .wd_s(wd_s), .alua_s(alua_s), .pcen(pcen), .regwrite(regwrite),
    .mem_we(mem_we), .signext_sign(signext_sign), .opcode(opcode), .opext(opext),
    .rsrc_addr(rsrc_addr), .rdest_addr(rdest_addr), .imm(imm), .illegal(illegal),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one cycle; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; instr = 16'h0000;
    alu_z = 1'b0; alu_n = 1'b0; alu_c = 1'b0; alu_f = 1'b0;
    @(negedge clk);
    tick();
    n_checks++;
    if ({dbg_state, pcen, regwrite, mem_we, illegal} !== 7'b000_0000) begin
      n_fail++; $display("FAIL reset_hold got=%b exp=%b", {dbg_state, pcen, regwrite, mem_we, illegal}, 7'b000_0000);
    end
    reset = 1'b0;
    n_checks++;
    if ({dbg_state, mem_s, pcen, regwrite, mem_we} !== 7'b000_0000) begin
      n_fail++; $display("FAIL reset_fetch got=%b exp=%b", {dbg_state, mem_s, pcen, regwrite, mem_we}, 7'b000_0000);
    end
    tick();
    n_checks++;
    if ({dbg_state, pcen, imm, alua_s, alub_s, opcode, opext, pc_s, signext_sign} !== {3'd1, 1'b1, 8'h01, 2'b01, 1'b1, 4'h0, 4'h5, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_latch got=%h exp=%h", {dbg_state, pcen, imm, alua_s, alub_s, opcode, opext, pc_s, signext_sign},
                         {3'd1, 1'b1, 8'h01, 2'b01, 1'b1, 4'h0, 4'h5, 1'b0, 1'b0});
    end
    tick();  // EXEC of 16'h0000: R-type with opext 0000 is undecodable
    n_checks++;
    if ({dbg_state, illegal, pcen, regwrite, mem_we} !== {3'd2, 4'b1000}) begin
      n_fail++; $display("FAIL reset_zero_instr got=%b exp=%b", {dbg_state, illegal, pcen, regwrite, mem_we}, {3'd2, 4'b1000});
    end
    tick();
  endtask

  task automatic test_add();
    instr = 16'h0351;
    tick(); tick();
    n_checks++;
    if ({opcode, opext, alua_s, alub_s, wd_s, wa_s, regwrite, pcen, mem_we, illegal, rdest_addr, rsrc_addr} !==
        {4'h0, 4'h5, 2'b00, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd1}) begin
      n_fail++; $display("FAIL add_exec got=%h exp=%h",
                         {opcode, opext, alua_s, alub_s, wd_s, wa_s, regwrite, pcen, mem_we, illegal, rdest_addr, rsrc_addr},
                         {4'h0, 4'h5, 2'b00, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd1});
    end
    tick();
    n_checks++;
    if (dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL add_next_fetch got=%0d exp=0", dbg_state);
    end
  endtask

  task automatic test_rtype_forms();
    logic [15:0] ins [4];
    logic [3:0]  ext [4];
    logic        rw  [4];
    ins = '{16'h05D2, 16'h01B2, 16'h0212, 16'h0731};  // MOV, CMP, AND, XOR
    ext = '{4'hD, 4'hB, 4'h1, 4'h3};
    rw  = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      instr = ins[i];
      tick(); tick();
      n_checks++;
      if ({opcode, opext, alub_s, wd_s, regwrite, illegal} !== {4'h0, ext[i], 1'b0, 2'b11, rw[i], 1'b0}) begin
        n_fail++; $display("FAIL rtype_%h got=%h exp=%h", ins[i], {opcode, opext, alub_s, wd_s, regwrite, illegal},
                           {4'h0, ext[i], 1'b0, 2'b11, rw[i], 1'b0});
      end
      tick();
    end
  endtask

  task automatic test_imm_forms();
    instr = 16'h1380;  // ANDI R3,#80: zero-extended
    tick(); tick();
    n_checks++;
    if ({opcode, opext, alub_s, alua_s, signext_sign, regwrite, imm} !== {4'h1, 4'h0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h80}) begin
      n_fail++; $display("FAIL andi_exec got=%h exp=%h", {opcode, opext, alub_s, alua_s, signext_sign, regwrite, imm},
                         {4'h1, 4'h0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h80});
    end
    tick();
    instr = 16'h9405;  // SUBI R4,#5: sign-extended
    tick(); tick();
    n_checks++;
    if ({opcode, opext, alub_s, signext_sign, regwrite, rdest_addr} !== {4'h9, 4'h0, 1'b1, 1'b1, 1'b1, 4'd4}) begin
      n_fail++; $display("FAIL subi_exec got=%h exp=%h", {opcode, opext, alub_s, signext_sign, regwrite, rdest_addr},
                         {4'h9, 4'h0, 1'b1, 1'b1, 1'b1, 4'd4});
    end
    tick();
    instr = 16'hD5A0;  // MOVI R5,#A0
    tick(); tick();
    n_checks++;
    if ({opcode, opext, alua_s, alub_s, signext_sign, wd_s, regwrite, imm} !== {4'h0, 4'h5, 2'b10, 1'b1, 1'b0, 2'b11, 1'b1, 8'hA0}) begin
      n_fail++; $display("FAIL movi_exec got=%h exp=%h", {opcode, opext, alua_s, alub_s, signext_sign, wd_s, regwrite, imm},
                         {4'h0, 4'h5, 2'b10, 1'b1, 1'b0, 2'b11, 1'b1, 8'hA0});
    end
    tick();
  endtask

  task automatic test_cmp_branch();
    alu_z = 1'b1;
    instr = 16'hB2FF;  // CMPI R2,-1
    tick(); tick();
    n_checks++;
    if ({regwrite, signext_sign, alub_s, opcode, opext, imm} !== {1'b0, 1'b1, 1'b1, 4'hB, 4'h0, 8'hFF}) begin
      n_fail++; $display("FAIL cmpi_exec got=%h exp=%h", {regwrite, signext_sign, alub_s, opcode, opext, imm},
                         {1'b0, 1'b1, 1'b1, 4'hB, 4'h0, 8'hFF});
    end
    tick();
    alu_z = 1'b0;
    instr = 16'hC0FE;  // BEQ -2, Z was set
    tick(); tick();
    n_checks++;
    if ({pcen, pc_s, alua_s, alub_s, signext_sign, opcode, opext, imm, regwrite} !== {1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 4'h0, 4'h5, 8'hFE, 1'b0}) begin
      n_fail++; $display("FAIL beq_taken got=%h exp=%h", {pcen, pc_s, alua_s, alub_s, signext_sign, opcode, opext, imm, regwrite},
                         {1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 4'h0, 4'h5, 8'hFE, 1'b0});
    end
    tick();
    instr = 16'hB2FF;  // CMPI again, Z now clear
    tick(); tick(); tick();
    instr = 16'hC0FE;
    tick(); tick();
    n_checks++;
    if ({dbg_state, pcen, regwrite, illegal} !== {3'd2, 3'b000}) begin
      n_fail++; $display("FAIL beq_not_taken got=%b exp=%b", {dbg_state, pcen, regwrite, illegal}, {3'd2, 3'b000});
    end
    tick();
    n_checks++;
    if (dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL beq_not_taken_len got=%0d exp=0", dbg_state);
    end
    instr = 16'hC1FE;  // BNE -2, Z still clear after a branch
    tick(); tick();
    n_checks++;
    if ({pcen, alua_s, alub_s} !== {1'b1, 2'b01, 1'b1}) begin
      n_fail++; $display("FAIL bne_taken got=%b exp=%b", {pcen, alua_s, alub_s}, {1'b1, 2'b01, 1'b1});
    end
    tick();
  endtask

  task automatic test_jcond_flags();
    alu_c = 1'b1; alu_z = 1'b0;
    instr = 16'hB201;  // CMPI sets C=1, Z=0
    tick(); tick(); tick();
    alu_c = 1'b0; alu_z = 1'b1;
    instr = 16'h0312;  // AND must leave flags untouched
    tick(); tick(); tick();
    alu_z = 1'b0;
    instr = 16'h42C7;  // Jcond C=1 -> taken
    tick(); tick();
    n_checks++;
    if ({pcen, pc_s, regwrite, rsrc_addr} !== {1'b1, 1'b1, 1'b0, 4'd7}) begin
      n_fail++; $display("FAIL jcs_taken got=%b exp=%b", {pcen, pc_s, regwrite, rsrc_addr}, {1'b1, 1'b1, 1'b0, 4'd7});
    end
    tick();
    instr = 16'h40C7;  // Jcond Z=1 -> not taken (AND did not write Z)
    tick(); tick();
    n_checks++;
    if ({pcen, illegal} !== 2'b00) begin
      n_fail++; $display("FAIL jeq_not_taken got=%b exp=%b", {pcen, illegal}, 2'b00);
    end
    tick();
    instr = 16'h4EC5;  // always
    tick(); tick();
    n_checks++;
    if ({pcen, pc_s} !== 2'b11) begin
      n_fail++; $display("FAIL juc_taken got=%b exp=%b", {pcen, pc_s}, 2'b11);
    end
    tick();
    instr = 16'h4FC5;  // code 1111 is never taken
    tick(); tick();
    n_checks++;
    if ({pcen, illegal} !== 2'b00) begin
      n_fail++; $display("FAIL jnever got=%b exp=%b", {pcen, illegal}, 2'b00);
    end
    tick();
  endtask

  task automatic test_load();
    instr = 16'h4402;
    tick(); tick();
    n_checks++;
    if ({dbg_state, pcen, regwrite, mem_we, illegal} !== {3'd2, 4'b0000}) begin
      n_fail++; $display("FAIL load_exec got=%b exp=%b", {dbg_state, pcen, regwrite, mem_we, illegal}, {3'd2, 4'b0000});
    end
    tick();
    n_checks++;
    if ({dbg_state, mem_s, pcen, regwrite, mem_we} !== {3'd3, 4'b1000}) begin
      n_fail++; $display("FAIL load_ldmem got=%b exp=%b", {dbg_state, mem_s, pcen, regwrite, mem_we}, {3'd3, 4'b1000});
    end
    tick();
    n_checks++;
    if ({dbg_state, wd_s, mem_s, regwrite, pcen, mem_we, rdest_addr, rsrc_addr} !== {3'd4, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 4'd2}) begin
      n_fail++; $display("FAIL load_ldwb got=%b exp=%b", {dbg_state, wd_s, mem_s, regwrite, pcen, mem_we, rdest_addr, rsrc_addr},
                         {3'd4, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 4'd2});
    end
    tick();
    n_checks++;
    if (dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL load_next_fetch got=%0d exp=0", dbg_state);
    end
  endtask

  task automatic test_reset_mid_load();
    instr = 16'h4402;
    tick(); tick(); tick();
    n_checks++;
    if (dbg_state !== 3'd3) begin
      n_fail++; $display("FAIL rst_mid_reach_ldmem got=%0d exp=3", dbg_state);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({dbg_state, pcen, regwrite, mem_we, illegal} !== 7'b000_0000) begin
      n_fail++; $display("FAIL rst_mid_async got=%b exp=%b", {dbg_state, pcen, regwrite, mem_we, illegal}, 7'b000_0000);
    end
    tick();
    n_checks++;
    if ({dbg_state, pcen, regwrite, mem_we, mem_s} !== 7'b000_0000) begin
      n_fail++; $display("FAIL rst_mid_hold got=%b exp=%b", {dbg_state, pcen, regwrite, mem_we, mem_s}, 7'b000_0000);
    end
    reset = 1'b0;
    instr = 16'h0351;
    tick();
    n_checks++;
    if ({dbg_state, pcen, imm, alua_s} !== {3'd1, 1'b1, 8'h01, 2'b01}) begin
      n_fail++; $display("FAIL rst_mid_latch got=%h exp=%h", {dbg_state, pcen, imm, alua_s}, {3'd1, 1'b1, 8'h01, 2'b01});
    end
    tick();
    n_checks++;
    if ({dbg_state, regwrite, rdest_addr, rsrc_addr} !== {3'd2, 1'b1, 4'd3, 4'd1}) begin
      n_fail++; $display("FAIL rst_mid_exec got=%h exp=%h", {dbg_state, regwrite, rdest_addr, rsrc_addr}, {3'd2, 1'b1, 4'd3, 4'd1});
    end
    tick();
  endtask

  task automatic test_jal_stor();
    instr = 16'h4E87;  // JAL R14,R7
    tick(); tick();
    n_checks++;
    if ({regwrite, wd_s, pc_s, pcen, mem_we, rdest_addr, rsrc_addr} !== {1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 4'd14, 4'd7}) begin
      n_fail++; $display("FAIL jal_exec got=%b exp=%b", {regwrite, wd_s, pc_s, pcen, mem_we, rdest_addr, rsrc_addr},
                         {1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 4'd14, 4'd7});
    end
    tick();
    instr = 16'h4043;  // STOR R0,[R3] (opext 0100)
    tick(); tick();
    n_checks++;
    if ({mem_we, mem_s, regwrite, pcen, rdest_addr, rsrc_addr} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3}) begin
      n_fail++; $display("FAIL stor_exec got=%b exp=%b", {mem_we, mem_s, regwrite, pcen, rdest_addr, rsrc_addr},
                         {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3});
    end
    tick();
    n_checks++;
    if ({dbg_state, mem_we} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL stor_next_fetch got=%b exp=%b", {dbg_state, mem_we}, {3'd0, 1'b0});
    end
  endtask

  task automatic test_illegal();
    logic [15:0] ins [3];
    ins = '{16'hF000, 16'h4010, 16'h0040};
    for (int i = 0; i < 3; i++) begin
      instr = ins[i];
      tick(); tick();
      n_checks++;
      if ({illegal, pcen, regwrite, mem_we} !== 4'b1000) begin
        n_fail++; $display("FAIL illegal_%h_exec got=%b exp=%b", ins[i], {illegal, pcen, regwrite, mem_we}, 4'b1000);
      end
      tick();
      n_checks++;
      if ({dbg_state, illegal} !== {3'd0, 1'b0}) begin
        n_fail++; $display("FAIL illegal_%h_after got=%b exp=%b", ins[i], {dbg_state, illegal}, {3'd0, 1'b0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_rtype_forms();
    test_imm_forms();
    test_cmp_branch();
    test_jcond_flags();
    test_load();
    test_jal_stor();
    test_illegal();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
